// File: rtl/pulse_cal_pkg.sv
// Shared constants and types for the pulse period calibrator.
package pulse_cal_pkg;
    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    typedef logic [WIDTH-1:0] count_t;
endpackage

// File: rtl/psi_edge_detect.sv
// Input conditioning for PSI: optional 2-flop synchronizer (PSI_SYNC_EN), delay flop, edge strobes.
module psi_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic psi,
    output logic psi_s,
    output logic rise,
    output logic fall
);
`ifdef PSI_SYNC_EN
    localparam int FILL = 3;
    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], psi};
        end
    end

    assign psi_s = sync_reg[1];
`else
    localparam int FILL = 1;

    assign psi_s = psi;
`endif

    logic            psi_d_reg;
    logic [FILL-1:0] valid_reg;

    // Edges are suppressed until every pipeline flop holds a real sample, so a
    // PSI already high at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            psi_d_reg <= 1'b0;
            valid_reg <= '0;
        end else begin
            psi_d_reg <= psi_s;
            valid_reg <= (valid_reg << 1) | FILL'(1);
        end
    end

    assign rise = valid_reg[FILL-1] &  psi_s & ~psi_d_reg;
    assign fall = valid_reg[FILL-1] & ~psi_s &  psi_d_reg;
endmodule

// File: rtl/pulse_period_calibrator.sv
// Measures PSI high time in prescaled ticks and steps adjustedDiv by +/-1 toward setPeriod.
// Optional macro PSI_SYNC_EN inserts a 2-flop synchronizer on PSI.
module pulse_period_calibrator
    import pulse_cal_pkg::*;
#(
    parameter int WIDTH = pulse_cal_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PSI,
    input  logic [WIDTH-1:0] setPeriod,
    output logic             equal,
    output logic [WIDTH-1:0] duration,
    output logic [WIDTH-1:0] adjustedDiv
);
    localparam logic [WIDTH-1:0] CMAX = {WIDTH{1'b1}};

    logic             psi_s;
    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] presc_reg;
    logic             armed_reg;
    logic             equal_reg;
    logic [WIDTH-1:0] duration_reg;
    logic [WIDTH-1:0] div_reg;

    psi_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .psi   (PSI),
        .psi_s (psi_s),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            presc_reg    <= '0;
            armed_reg    <= 1'b0;
            equal_reg    <= 1'b0;
            duration_reg <= '0;
            div_reg      <= '0;
        end else begin
            if (rise) begin
                count_reg <= '0;
                presc_reg <= '0;
                armed_reg <= 1'b1;
            end else if (psi_s && armed_reg) begin
                if (presc_reg == div_reg) begin
                    presc_reg <= '0;
                    if (count_reg != CMAX) begin
                        count_reg <= count_reg + 1'b1;
                    end
                end else begin
                    presc_reg <= presc_reg + 1'b1;
                end
            end

            // Divisor only moves on a completed pulse, so it is stable while counting.
            if (fall && armed_reg) begin
                armed_reg    <= 1'b0;
                duration_reg <= count_reg;
                equal_reg    <= (count_reg == setPeriod);
                if (count_reg > setPeriod) begin
                    if (div_reg != CMAX) begin
                        div_reg <= div_reg + 1'b1;
                    end
                end else if (count_reg < setPeriod) begin
                    if (div_reg != '0) begin
                        div_reg <= div_reg - 1'b1;
                    end
                end
            end
        end
    end

    assign equal       = equal_reg;
    assign duration    = duration_reg;
    assign adjustedDiv = div_reg;
endmodule

// File: tb/tb_pulse_period_calibrator.sv
// Directed self-checking bench for pulse_period_calibrator.
module tb_pulse_period_calibrator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PSI = 1'b0;
    logic [7:0] setPeriod = 8'd0;
    logic       equal;
    logic [7:0] duration;
    logic [7:0] adjustedDiv;

    int errors = 0;
    int checks = 0;

    pulse_period_calibrator dut (
        .clk         (clk),
        .rst         (rst),
        .PSI         (PSI),
        .setPeriod   (setPeriod),
        .equal       (equal),
        .duration    (duration),
        .adjustedDiv (adjustedDiv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic e_eq, input logic [7:0] e_dur,
                              input logic [7:0] e_div);
        check({tag, ".equal"}, {31'd0, equal}, {31'd0, e_eq});
        check({tag, ".duration"}, {24'd0, duration}, {24'd0, e_dur});
        check({tag, ".adjustedDiv"}, {24'd0, adjustedDiv}, {24'd0, e_div});
        $display("%0t %s: equal=%0d duration=%0d adjustedDiv=%0d", $time, tag, equal, duration, adjustedDiv);
    endtask

    // PSI is sampled high on exactly n rising edges, then allowed to settle.
    task automatic pulse(input int n);
        PSI = 1'b1;
        repeat (n) @(posedge clk);
        #1 PSI = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 1'b0, 8'd0, 8'd0);

        setPeriod = 8'd24;
        pulse(25);
        expect_out("match", 1'b1, 8'd24, 8'd0);

        pulse(5);
        expect_out("too_short", 1'b0, 8'd4, 8'd0);

        setPeriod = 8'd10;
        pulse(30);
        expect_out("too_long1", 1'b0, 8'd29, 8'd1);
        pulse(30);
        expect_out("too_long2", 1'b0, 8'd14, 8'd2);

        do_reset(3);
        setPeriod = 8'd255;
        pulse(300);
        expect_out("saturate", 1'b1, 8'd255, 8'd0);

        // PSI high across reset release: the following fall must be ignored.
        PSI = 1'b1;
        do_reset(3);
        repeat (5) @(posedge clk);
        #1 PSI = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        expect_out("high_at_release", 1'b0, 8'd0, 8'd0);

        // Reset in the middle of a pulse aborts it; a fresh pulse then measures normally.
        setPeriod = 8'd24;
        PSI = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_out("mid_reset", 1'b0, 8'd0, 8'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 PSI = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        pulse(25);
        expect_out("after_abort", 1'b1, 8'd24, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
